// File: rtl/id_ex_pipe_reg.sv
// ----------------------------------------------------------------------------
// id_ex_pipe_reg
//   ID/EX pipeline register with load-use hazard detection.
//
//   Captures the decoded control bits and operands leaving ID and presents
//   them to EX one cycle later. When the instruction in EX is a load whose
//   destination (rt) is read by the instruction in ID, Stall_o is raised and
//   a NOP bubble (all control bits cleared) is loaded instead, so the
//   dependent instruction is re-presented one cycle later. A taken
//   branch/jump (flush_i) also loads a bubble but never raises a stall. A
//   memory stall (hold_i) freezes every register.
//
//   Optional feature, selected by the BUBBLE_CNT_EN macro:
//     defined   : BubbleCnt_o is a saturating 32-bit count of inserted bubbles.
//     undefined : no counter flops; BubbleCnt_o is tied to zero.
// ----------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              hold_i,
    input  logic              flush_i,

    input  logic              RegDst_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              ALUSrc_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              RegWrite_i,
    input  logic              MemToReg_i,

    input  logic [DATA_W-1:0] RSdata_i,
    input  logic [DATA_W-1:0] RTdata_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [REG_AW-1:0] RSaddr_i,
    input  logic [REG_AW-1:0] RTaddr_i,
    input  logic [REG_AW-1:0] RDaddr_i,

    output logic              RegDst_o,
    output logic [1:0]        ALUOp_o,
    output logic              ALUSrc_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              RegWrite_o,
    output logic              MemToReg_o,

    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic [DATA_W-1:0] Imm_o,
    output logic [REG_AW-1:0] RSaddr_o,
    output logic [REG_AW-1:0] RTaddr_o,
    output logic [REG_AW-1:0] RDaddr_o,

    output logic              Stall_o,
    output logic [31:0]       BubbleCnt_o
);

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    logic rt_is_zero;
    logic rs_match;
    logic rt_match;
    logic hazard;
    logic insert_bubble;
    logic advance;

    // Register $0 is hard-wired to zero, so a load "into" it never creates a
    // real dependency and must not stall.
    assign rt_is_zero = (RTaddr_o == '0);
    assign rs_match   = (RTaddr_o == RSaddr_i);
    assign rt_match   = (RTaddr_o == RTaddr_i);

    // A load sitting in EX whose destination is read by the ID instruction.
    // Once the bubble is in EX, MemRead_o is 0, so this drops on its own and
    // the stall lasts exactly one cycle.
    assign hazard = MemRead_o & ~rt_is_zero & (rs_match | rt_match);

    // A flush throws the ID instruction away, so stalling would only lose the
    // branch target fetched behind it.
    assign Stall_o = hazard & ~flush_i;

    // Both a flush and a load-use hazard put a NOP into EX.
    assign insert_bubble = flush_i | hazard;

    // hold_i has top priority and freezes every register in the block.
    assign advance = ~hold_i;

    // ------------------------------------------------------------------------
    // Control bits: cleared when a bubble is inserted
    // ------------------------------------------------------------------------
    // Control fields load from ID, or are zeroed to form a bubble.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of the others; the async reset sits in the sensitivity
    // list so it acts without waiting for a clock edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            RegDst_o   <= 1'b0;
            ALUOp_o    <= 2'b00;
            ALUSrc_o   <= 1'b0;
            MemRead_o  <= 1'b0;
            MemWrite_o <= 1'b0;
            RegWrite_o <= 1'b0;
            MemToReg_o <= 1'b0;
        end else if (advance) begin
            if (insert_bubble) begin
                RegDst_o   <= 1'b0;
                ALUOp_o    <= 2'b00;
                ALUSrc_o   <= 1'b0;
                MemRead_o  <= 1'b0;
                MemWrite_o <= 1'b0;
                RegWrite_o <= 1'b0;
                MemToReg_o <= 1'b0;
            end else begin
                RegDst_o   <= RegDst_i;
                ALUOp_o    <= ALUOp_i;
                ALUSrc_o   <= ALUSrc_i;
                MemRead_o  <= MemRead_i;
                MemWrite_o <= MemWrite_i;
                RegWrite_o <= RegWrite_i;
                MemToReg_o <= MemToReg_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Data and address fields: always follow ID unless held
    // ------------------------------------------------------------------------
    // Operands load even during a bubble; with every control bit zero nothing
    // downstream consumes or writes them, so they are don't-care there.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            RSdata_o <= '0;
            RTdata_o <= '0;
            Imm_o    <= '0;
            RSaddr_o <= '0;
            RTaddr_o <= '0;
            RDaddr_o <= '0;
        end else if (advance) begin
            RSdata_o <= RSdata_i;
            RTdata_o <= RTdata_i;
            Imm_o    <= Imm_i;
            RSaddr_o <= RSaddr_i;
            RTaddr_o <= RTaddr_i;
            RDaddr_o <= RDaddr_i;
        end
    end

    // ------------------------------------------------------------------------
    // Bubble counter
    // ------------------------------------------------------------------------
`ifdef BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
    logic        cnt_full;

    assign cnt_full = (bubble_cnt == 32'hFFFF_FFFF);

    // Counts every bubble loaded (flush or hazard, once per edge), saturating.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt <= 32'd0;
        end else if (advance && insert_bubble && !cnt_full) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    assign BubbleCnt_o = bubble_cnt;
`else
    // Counter disabled: the port is kept so the interface is build-invariant.
    assign BubbleCnt_o = 32'd0;
`endif

endmodule
